// File: rtl/ln_lut_arbiter_if.sv
// Bundle of request, LUT and response signals for the shared ln_lut arbiter.
// The slave modport is the arbiter; the master modport is its environment
// (requesters, the ln_lut instance and the response consumer).
interface ln_lut_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [7*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]   req_ready;
  logic               lut_en;
  logic [6:0]         lut_x;
  logic signed [31:0] lut_res;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic signed [31:0] rsp_data;
  logic               rsp_err;
  logic               busy;

  modport slave (
    input  req_valid, req_x, lut_res, rsp_ready,
    output req_ready, lut_en, lut_x, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_x, lut_res, rsp_ready,
    input  req_ready, lut_en, lut_x, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/ln_lut_arbiter.sv
// Round-robin arbiter sharing one registered ln_lut (x in 1..100 -> Q8.24
// ln(x/100)) among N_REQ requesters. One lookup in flight at a time:
// IDLE -> ISSUE -> WAIT -> RESP, with out-of-range operands bypassing WAIT
// and answering with an error response.
module ln_lut_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  ln_lut_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic signed [31:0] ERR_DATA = 32'sh8000_0000;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    win_q, win_d;
  logic [6:0]         x_q, x_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic signed [31:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [ID_W-1:0]    win_idx;
  int                 idx;
  logic [N_REQ-1:0]   grant;
  logic               lut_en;
  logic               x_in_range;

  // Round-robin scan: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
  end

  assign x_in_range = (x_q != 7'd0) && (x_q <= 7'd100);

  // Next-state, grant and LUT-drive logic for the lookup sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    x_d         = x_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    grant       = '0;
    lut_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant[win_idx] = 1'b1;
          win_d          = win_idx;
          x_d            = bus.req_x[7*int'(win_idx) +: 7];
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_d = ID_W'((int'(win_q) + 1) % N_REQ);
        rsp_id_d = win_q;
        if (x_in_range) begin
          lut_en  = 1'b1;
          state_d = WAIT;
        end else begin
          rsp_err_d   = 1'b1;
          rsp_data_d  = ERR_DATA;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      WAIT: begin
        rsp_data_d  = bus.lut_res;
        rsp_err_d   = 1'b0;
        rsp_id_d    = win_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // The grant is combinational in IDLE; forcing it low while reset is held
  // keeps every output at zero during reset even with requests pending.
  assign bus.req_ready = rst_n ? grant : '0;
  assign bus.lut_en    = lut_en;
  assign bus.lut_x     = lut_en ? x_q : 7'd0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

  // State and registered outputs; reset discards any in-flight lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      x_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      x_q         <= x_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ln_lut_arbiter.sv
// Bench for ln_lut_arbiter: models the registered ln_lut, runs a table of
// single-requester lookups, then hand-written sequences for round-robin
// ordering, response back-pressure and mid-lookup reset.
module tb_ln_lut_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  localparam logic [31:0] LN_1   = -32'sd77261934;
  localparam logic [31:0] LN_10  = -32'sd38630967;
  localparam logic [31:0] LN_20  = -32'sd27001887;
  localparam logic [31:0] LN_30  = -32'sd20199311;
  localparam logic [31:0] LN_40  = -32'sd15372807;
  localparam logic [31:0] LN_50  = -32'sd11629079;
  localparam logic [31:0] LN_100 = 32'd0;
  localparam logic [31:0] ERRD   = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ln_lut_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  ln_lut_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int lut_pulses = 0;
  int viol = 0;

  function automatic logic [31:0] ln_ref(input logic [6:0] x);
    case (x)
      7'd1:    return LN_1;
      7'd10:   return LN_10;
      7'd20:   return LN_20;
      7'd30:   return LN_30;
      7'd40:   return LN_40;
      7'd50:   return LN_50;
      7'd100:  return LN_100;
      default: return 32'h0BAD_0000 | {25'd0, x};
    endcase
  endfunction

  // ln_lut model: result one cycle after en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.lut_en) lut_pulses++;
    bus.lut_res <= bus.lut_en ? ln_ref(bus.lut_x) : 32'hDEAD_BEEF;
  end

  // Continuous protocol watch, summarised in one comparison at the end.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.lut_en && bus.lut_x != 7'd0) viol++;
      if ($countones(bus.req_ready) > 1) viol++;
      if (bus.busy && bus.req_ready != '0) viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [6:0]  x;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v);
    int n;
    int p0;
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_valid[v.id] = 1'b1;
    bus.req_x[7*v.id +: 7] = v.x;
    #1;
    chk("grant", 32'(bus.req_ready), 32'(1 << v.id));
    p0 = lut_pulses;
    @(negedge clk);
    bus.req_valid = '0;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, v.err ? 2 : 3);
    chk("rsp_id", 32'(bus.rsp_id), v.id);
    chk("rsp_data", bus.rsp_data, v.data);
    chk("rsp_err", 32'(bus.rsp_err), 32'(v.err));
    chk("lut_en_pulses", lut_pulses - p0, v.err ? 0 : 1);
    @(negedge clk);
    chk("rsp_valid_drop", {bus.busy, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int order[5];
    logic [31:0] exp4[4];
    logic [31:0] d_hold;

    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.rsp_ready = 1'b1;

    vecs[0] = '{0, 7'd50,  1'b0, LN_50};
    vecs[1] = '{2, 7'd100, 1'b0, LN_100};
    vecs[2] = '{2, 7'd1,   1'b0, LN_1};
    vecs[3] = '{1, 7'd0,   1'b1, ERRD};
    vecs[4] = '{1, 7'd127, 1'b1, ERRD};
    vecs[5] = '{3, 7'd101, 1'b1, ERRD};

    // Reset state
    #12;
    chk("rst_outputs", {bus.rsp_valid, bus.busy, bus.lut_en, bus.rsp_err, bus.lut_x}, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single lookups (last entry is req 3, so rr_ptr returns to 0)
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // All four requesting continuously: order 0,1,2,3,0 at one per 4 cycles
    order = '{0, 1, 2, 3, 0};
    exp4  = '{LN_10, LN_20, LN_30, LN_40};
    @(negedge clk);
    bus.req_x     = {7'd40, 7'd30, 7'd20, 7'd10};
    bus.req_valid = 4'hF;
    #1;
    chk("rr_first_grant", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.rsp_valid && n < 10);
      chk("rr_interval", n, (k == 0) ? 3 : 4);
      chk("rr_id", 32'(bus.rsp_id), order[k]);
      chk("rr_data", bus.rsp_data, exp4[order[k]]);
    end
    bus.req_valid = '0;
    @(negedge clk);
    chk("rr_idle", 32'(bus.busy), 32'd0);

    // Back-pressure: rr_ptr is 1, so req 1 wins over req 0
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_x     = {7'd0, 7'd0, 7'd20, 7'd50};
    bus.req_valid = 4'b0011;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 10);
    chk("bp_id", 32'(bus.rsp_id), 32'd1);
    chk("bp_data", bus.rsp_data, LN_20);
    d_hold = bus.rsp_data;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data_hold", bus.rsp_data, d_hold);
      chk("bp_id_hold", {bus.rsp_err, bus.rsp_id}, 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    // Release the consumer while req 0 withdraws before ever being granted
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    chk("drop_no_grant", {bus.req_ready, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("drop_idle", 32'(bus.busy), 32'd0);

    // Reset during WAIT
    bus.req_x     = {7'd0, 7'd30, 7'd0, 7'd50};
    bus.req_valid = 4'b0100;
    #1;
    chk("pre_rst_grant", 32'(bus.req_ready), 32'd4);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    chk("arst_ctrl", {bus.rsp_valid, bus.busy, bus.lut_en, bus.rsp_err, bus.lut_x}, 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_data", bus.rsp_data, 32'd0);
    chk("arst_id", 32'(bus.rsp_id), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_latency", n, 3);
    chk("post_rst_id", 32'(bus.rsp_id), 32'd0);
    chk("post_rst_data", bus.rsp_data, LN_50);
    @(negedge clk);
    @(negedge clk);

    chk("protocol_watch", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
